regfile_access_ctrl: RTL and testbench
======================================

Name: regfile_access_ctrl

Overview:
- Initiator-side controller for the 16x16 CPU register file. It turns a valid/ready command stream (single read or write) into register-file port activity, and returns read data on a valid/ready response stream.
- Also provides a dump mode. Dump walks registers from index 0 to DUMP_LAST and streams each one out, for the Pong debug/VGA overlay and for bench checking.
- Sits between the debug/host logic and the register file's write-enable, address, data and read-data ports.

Parameters:
- ADDR_W, 4, register address width.
- DATA_W, 16, register data width.
- DUMP_LAST, 15, last register index streamed in dump mode; must be <= 2^ADDR_W-1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at the clock edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target register.
- cmd_wdata  in  DATA_W  write data.
- dump_start  in  1  single-cycle request to start a dump; sampled only in IDLE.
- rf_En  out  1  register-file write enable.
- rf_readwrite_addr  out  ADDR_W  register-file write address.
- rf_write_data  out  DATA_W  register-file write data.
- rf_read_addr  out  ADDR_W  register-file read address (combinational read port).
- rf_read_data  in  DATA_W  register-file read data; combinational from rf_read_addr.
- rsp_valid  out  1  response beat valid.
- rsp_ready  in  1  consumer accepts the beat.
- rsp_addr  out  ADDR_W  register index of the beat.
- rsp_data  out  DATA_W  register contents.
- rsp_last  out  1  final beat of a dump; always 1 for a single read.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, WRITE, READ, DUMP, DRAIN.
- Reset (synchronous, clock edge with Reset=1), from any state including mid-dump or mid-write:
  - state=IDLE.
  - rf_En=0, rf_readwrite_addr=0, rf_write_data=0.
  - Internal address register=0, so rf_read_addr=0.
  - rsp_valid=0, rsp_addr=0, rsp_data=0, rsp_last=0, busy=0.
  - Any in-flight beat is discarded.
- cmd_ready = (state==IDLE) && !dump_start, combinational. dump_start has priority over a simultaneous command.
- IDLE:
  - dump_start=1: address register <= 0, go to DUMP.
  - Else, command accepted with cmd_write=1: latch rf_readwrite_addr=cmd_addr and rf_write_data=cmd_wdata, set rf_En=1, go to WRITE.
  - Else, command accepted with cmd_write=0: address register <= cmd_addr, go to READ.
- WRITE: rf_En is high for exactly this one cycle, and the register file captures at the end of it. Next edge: rf_En=0, go to IDLE. No response beat is produced.
- rf_read_addr is driven from the address register in all states.
- READ: at the edge, rsp_data <= rf_read_data, rsp_addr <= address register, rsp_last <= 1, rsp_valid <= 1, go to DRAIN.
  - Latency: command accept edge to rsp_valid high = 2 edges.
- DUMP: a slot is free when (!rsp_valid || rsp_ready). On each edge with a free slot:
  - Load rsp_data <= rf_read_data, rsp_addr <= address register, rsp_last <= (address == DUMP_LAST), rsp_valid <= 1.
  - If address == DUMP_LAST, go to DRAIN; else address register += 1.
  - With rsp_ready held high this yields one beat per cycle, consecutive, indices 0..DUMP_LAST.
- DRAIN: hold until rsp_valid && rsp_ready, then rsp_valid <= 0, rsp_last <= 0, go to IDLE.
- Response handshake rules:
  - While rsp_valid && !rsp_ready, rsp_addr, rsp_data and rsp_last are held stable.
  - No beat is dropped, duplicated or skipped.
  - rsp_valid never deasserts without a handshake, except on Reset.
- Commands while busy are not accepted (cmd_ready=0). dump_start outside IDLE is ignored.
- Write-then-read ordering: a read accepted in the cycle after WRITE returns the new value, because the write commits at the end of the WRITE cycle.
- The address counter does not wrap: the dump stops at DUMP_LAST.
- Arithmetic is unsigned, modulo 2^ADDR_W, and never reached given the DUMP_LAST constraint.

Test Plan:
- Write then read: write R3=0xBEEF, then read R3 with rsp_ready=1.
  - Required: rf_En high exactly 1 cycle with rf_readwrite_addr=3, rf_write_data=0xBEEF.
  - Required: rsp_valid 2 edges after read accept, rsp_addr=3, rsp_data=0xBEEF, rsp_last=1.
- Full dump, no backpressure: preload Rn = 0x1000+n, pulse dump_start, rsp_ready=1.
  - Required: 16 consecutive beats with rsp_addr 0..15 and data 0x1000..0x100F.
  - Required: rsp_last only on addr 15; busy drops 1 cycle after the last handshake.
- Dump with backpressure: drop rsp_ready for 3 cycles while beat addr=5 is valid.
  - Required: rsp_addr=5 and rsp_data=0x1005 are held stable; the next beat is addr 6.
  - Required: total beats = 16, no gaps in addresses.
- Simultaneous start: dump_start=1 and cmd_valid=1 (write R7) in the same IDLE cycle.
  - Required: cmd_ready=0, the dump starts, no rf_En pulse.
  - Required: the write is accepted after the dump completes, and R7 reads back the new value.
- Reset mid-dump: assert Reset for 1 cycle while beat addr=7 is pending.
  - Required: next cycle rsp_valid=0, busy=0, rf_En=0, rsp_data=0.
  - Required: a fresh dump restarts from addr 0.
- Busy rejection: cmd_valid=1 (read R2) held throughout a dump.
  - Required: cmd_ready=0 until IDLE.
  - Required: the read is then accepted exactly once and returns R2's value.

Source files
------------

// File: rtl/regfile_access_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_access_ctrl
//
// Initiator-side controller for the CPU register file. The controller accepts
// single read or write commands on a valid/ready stream and drives the
// register-file ports. Read data comes back on a valid/ready response stream.
// A dump mode walks registers 0..DUMP_LAST and streams each one out as a
// response beat. The last beat of a dump carries rsp_last.
//
// Ports
//   clk                in   clock, all state changes on the rising edge
//   Reset              in   synchronous, active-high reset
//   cmd_valid          in   command present
//   cmd_ready          out  command accepted when cmd_valid && cmd_ready
//   cmd_write          in   1 = write, 0 = read
//   cmd_addr           in   target register index
//   cmd_wdata          in   write data
//   dump_start         in   single-cycle dump request, sampled only in IDLE
//   rf_En              out  register-file write enable (one cycle per write)
//   rf_readwrite_addr  out  register-file write address
//   rf_write_data      out  register-file write data
//   rf_read_addr       out  register-file read address (combinational port)
//   rf_read_data       in   register-file read data, combinational from addr
//   rsp_valid          out  response beat valid
//   rsp_ready          in   consumer accepts the beat
//   rsp_addr           out  register index of the beat
//   rsp_data           out  register contents
//   rsp_last           out  final beat of a dump; always 1 for a single read
//   busy               out  controller is not idle
// ---------------------------------------------------------------------------
module regfile_access_ctrl #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 16,
    parameter int DUMP_LAST = 15
) (
    input  logic              clk,
    input  logic              Reset,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,

    input  logic              dump_start,

    output logic              rf_En,
    output logic [ADDR_W-1:0] rf_readwrite_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic [ADDR_W-1:0] rf_read_addr,
    input  logic [DATA_W-1:0] rf_read_data,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_last,

    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DUMP,
        S_DRAIN
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DUMP_LAST);

    state_t              state_q;
    state_t              state_d;

    // The address register feeds the read port directly. The read port is
    // combinational, so the data for the addressed register is available in
    // the same cycle.
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_d;

    logic                wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_d;
    logic [DATA_W-1:0]   wr_data_d;

    logic                rsp_valid_d;
    logic [ADDR_W-1:0]   rsp_addr_d;
    logic [DATA_W-1:0]   rsp_data_d;
    logic                rsp_last_d;

    // The output beat register can take a new beat when it is empty or when
    // its current beat is handed off on this edge.
    logic                slot_free;

    assign slot_free    = !rsp_valid || rsp_ready;
    // A dump request wins over a command that arrives in the same cycle.
    // The command is therefore refused while dump_start is high.
    assign cmd_ready    = (state_q == S_IDLE) && !dump_start;
    assign busy         = (state_q != S_IDLE);
    assign rf_read_addr = addr_q;

    // -----------------------------------------------------------------------
    // Next-state and next-output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = rf_readwrite_addr;
        wr_data_d   = rf_write_data;
        rsp_valid_d = rsp_valid;
        rsp_addr_d  = rsp_addr;
        rsp_data_d  = rsp_data;
        rsp_last_d  = rsp_last;

        case (state_q)
            S_IDLE: begin
                if (dump_start) begin
                    addr_d  = '0;
                    state_d = S_DUMP;
                end else if (cmd_valid && cmd_ready) begin
                    if (cmd_write) begin
                        wr_addr_d = cmd_addr;
                        wr_data_d = cmd_wdata;
                        wr_en_d   = 1'b1;
                        state_d   = S_WRITE;
                    end else begin
                        addr_d  = cmd_addr;
                        state_d = S_READ;
                    end
                end
            end

            // The register file captures the write at the end of this
            // cycle. wr_en_d defaults low, so the enable drops on this edge.
            S_WRITE: begin
                state_d = S_IDLE;
            end

            S_READ: begin
                rsp_data_d  = rf_read_data;
                rsp_addr_d  = addr_q;
                rsp_last_d  = 1'b1;
                rsp_valid_d = 1'b1;
                state_d     = S_DRAIN;
            end

            S_DUMP: begin
                if (slot_free) begin
                    rsp_data_d  = rf_read_data;
                    rsp_addr_d  = addr_q;
                    rsp_last_d  = (addr_q == LAST_IDX);
                    rsp_valid_d = 1'b1;
                    if (addr_q == LAST_IDX) begin
                        state_d = S_DRAIN;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end

            // Wait for the final beat (single read or last dump beat) to be
            // taken before the controller accepts new work.
            S_DRAIN: begin
                if (rsp_valid && rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_last_d  = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q           <= S_IDLE;
            addr_q            <= '0;
            rf_En             <= 1'b0;
            rf_readwrite_addr <= '0;
            rf_write_data     <= '0;
            rsp_valid         <= 1'b0;
            rsp_addr          <= '0;
            rsp_data          <= '0;
            rsp_last          <= 1'b0;
        end else begin
            state_q           <= state_d;
            addr_q            <= addr_d;
            rf_En             <= wr_en_d;
            rf_readwrite_addr <= wr_addr_d;
            rf_write_data     <= wr_data_d;
            rsp_valid         <= rsp_valid_d;
            rsp_addr          <= rsp_addr_d;
            rsp_data          <= rsp_data_d;
            rsp_last          <= rsp_last_d;
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_access_ctrl
//
// Bench for regfile_access_ctrl. A 16x16 register-file array is attached to
// the DUT ports. A reference copy of the register contents is kept at the
// command level, and expected responses and dump streams are derived from it.
// ---------------------------------------------------------------------------
module tb_regfile_access_ctrl;

    localparam int AW   = 4;
    localparam int DW   = 16;
    localparam int LAST = 15;

    logic          clk = 1'b0;
    logic          Reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          dump_start;
    logic          rf_En;
    logic [AW-1:0] rf_readwrite_addr;
    logic [DW-1:0] rf_write_data;
    logic [AW-1:0] rf_read_addr;
    logic [DW-1:0] rf_read_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_data;
    logic          rsp_last;
    logic          busy;

    int total = 0;
    int bad   = 0;

    // Register file attached to the controller
    logic [DW-1:0] rf_mem   [2**AW];
    // Expected register contents, updated when a write command is accepted
    logic [DW-1:0] ref_regs [2**AW];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_En) rf_mem[rf_readwrite_addr] <= rf_write_data;
    end
    assign rf_read_data = rf_mem[rf_read_addr];

    regfile_access_ctrl #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .DUMP_LAST (LAST)
    ) dut (
        .clk               (clk),
        .Reset             (Reset),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .cmd_write         (cmd_write),
        .cmd_addr          (cmd_addr),
        .cmd_wdata         (cmd_wdata),
        .dump_start        (dump_start),
        .rf_En             (rf_En),
        .rf_readwrite_addr (rf_readwrite_addr),
        .rf_write_data     (rf_write_data),
        .rf_read_addr      (rf_read_addr),
        .rf_read_data      (rf_read_data),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_addr          (rsp_addr),
        .rsp_data          (rsp_data),
        .rsp_last          (rsp_last),
        .busy              (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cmd_ready(input string tag);
        int n;
        n = 0;
        #1;
        while (!cmd_ready && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk(tag, 32'(cmd_ready), 32'd1);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = a;
        cmd_wdata = d;
        wait_cmd_ready("wr_ready");
        tick();
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        ref_regs[a] = d;
        chk("wr_en_on",   32'(rf_En), 32'd1);
        chk("wr_addr",    32'(rf_readwrite_addr), 32'(a));
        chk("wr_data",    32'(rf_write_data), 32'(d));
        tick();
        chk("wr_en_off",  32'(rf_En), 32'd0);
        chk("wr_idle",    32'(busy), 32'd0);
        chk("wr_no_rsp",  32'(rsp_valid), 32'd0);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int delay);
        logic [DW-1:0] exp;
        rsp_ready = (delay == 0);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = a;
        wait_cmd_ready("rd_ready");
        tick();
        cmd_valid = 1'b0;
        exp = ref_regs[a];
        chk("rd_lat_lo",  32'(rsp_valid), 32'd0);
        chk("rd_busy",    32'(busy), 32'd1);
        chk("rd_nordy",   32'(cmd_ready), 32'd0);
        tick();
        chk("rd_vld",     32'(rsp_valid), 32'd1);
        chk("rd_addr",    32'(rsp_addr), 32'(a));
        chk("rd_data",    32'(rsp_data), 32'(exp));
        chk("rd_last",    32'(rsp_last), 32'd1);
        for (int i = 0; i < delay; i++) begin
            tick();
            chk("rd_hold_vld",  32'(rsp_valid), 32'd1);
            chk("rd_hold_data", 32'(rsp_data), 32'(exp));
            chk("rd_hold_addr", 32'(rsp_addr), 32'(a));
        end
        rsp_ready = 1'b1;
        tick();
        chk("rd_done_vld",  32'(rsp_valid), 32'd0);
        chk("rd_done_busy", 32'(busy), 32'd0);
    endtask

    // Runs one dump. hold_addr/hold_len: withhold rsp_ready for hold_len
    // cycles while the beat at hold_addr is valid. reset_addr >= 0: pulse
    // Reset while that beat is pending and stop there.
    task automatic do_dump(input int hold_addr, input int hold_len, input int reset_addr);
        int            k;
        int            cyc;
        int            held;
        bit            stall_prev;
        bit            done;
        logic [AW-1:0] pa;
        logic [DW-1:0] pd;
        logic          pl;
        k = 0; cyc = 0; held = 0; stall_prev = 1'b0; done = 1'b0;
        pa = '0; pd = '0; pl = 1'b0;
        dump_start = 1'b1;
        #1;
        chk("dump_cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        dump_start = 1'b0;
        chk("dump_no_wr", 32'(rf_En), 32'd0);
        chk("dump_busy",  32'(busy), 32'd1);
        while (!done && cyc < 200) begin
            if (reset_addr >= 0 && rsp_valid && int'(rsp_addr) == reset_addr) begin
                Reset     = 1'b1;
                rsp_ready = 1'b0;
                tick();
                Reset     = 1'b0;
                rsp_ready = 1'b1;
                chk("rst_vld",     32'(rsp_valid), 32'd0);
                chk("rst_busy",    32'(busy), 32'd0);
                chk("rst_en",      32'(rf_En), 32'd0);
                chk("rst_data",    32'(rsp_data), 32'd0);
                chk("rst_addr",    32'(rsp_addr), 32'd0);
                chk("rst_last",    32'(rsp_last), 32'd0);
                chk("rst_rdaddr",  32'(rf_read_addr), 32'd0);
                chk("rst_beats",   32'(k), 32'(reset_addr));
                return;
            end
            if (stall_prev) begin
                chk("hold_vld",  32'(rsp_valid), 32'd1);
                chk("hold_addr", 32'(rsp_addr), 32'(pa));
                chk("hold_data", 32'(rsp_data), 32'(pd));
                chk("hold_last", 32'(rsp_last), 32'(pl));
            end
            if (rsp_valid && int'(rsp_addr) == hold_addr && held < hold_len) begin
                rsp_ready = 1'b0;
                held++;
            end else begin
                rsp_ready = 1'b1;
            end
            if (cmd_valid) chk("dump_cmd_blocked", 32'(cmd_ready), 32'd0);
            if (rsp_valid && rsp_ready) begin
                chk("dump_addr", 32'(rsp_addr), 32'(k));
                chk("dump_data", 32'(rsp_data), 32'(ref_regs[k]));
                chk("dump_last", 32'(rsp_last), 32'(k == LAST));
                if (rsp_last) done = 1'b1;
                k++;
            end
            stall_prev = rsp_valid && !rsp_ready;
            pa = rsp_addr;
            pd = rsp_data;
            pl = rsp_last;
            tick();
            cyc++;
        end
        chk("dump_beats",    32'(k), 32'(LAST + 1));
        chk("dump_cycles",   32'(cyc), 32'(LAST + 2 + hold_len));
        chk("dump_end_busy", 32'(busy), 32'd0);
        chk("dump_end_vld",  32'(rsp_valid), 32'd0);
        rsp_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] ra;
        Reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_write  = 1'b0;
        cmd_addr   = '0;
        cmd_wdata  = '0;
        dump_start = 1'b0;
        rsp_ready  = 1'b1;
        repeat (2) tick();
        Reset = 1'b0;

        // Reset state
        chk("reset_busy",   32'(busy), 32'd0);
        chk("reset_vld",    32'(rsp_valid), 32'd0);
        chk("reset_en",     32'(rf_En), 32'd0);
        chk("reset_waddr",  32'(rf_readwrite_addr), 32'd0);
        chk("reset_wdata",  32'(rf_write_data), 32'd0);
        chk("reset_rdaddr", 32'(rf_read_addr), 32'd0);
        chk("reset_rdata",  32'(rsp_data), 32'd0);
        chk("reset_raddr",  32'(rsp_addr), 32'd0);
        chk("reset_last",   32'(rsp_last), 32'd0);
        chk("reset_ready",  32'(cmd_ready), 32'd1);

        // Write then read back immediately
        do_write(4'd3, 16'hBEEF);
        do_read(4'd3, 0);

        // Preload Rn = 0x1000 + n
        for (int n = 0; n <= LAST; n++) do_write(AW'(n), DW'(16'h1000 + n));

        // Full dump without and with backpressure
        do_dump(-1, 0, -1);
        do_dump(5, 3, -1);

        // Dump request and write command in the same idle cycle
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 4'd7;
        cmd_wdata = 16'hA5A5;
        do_dump(-1, 0, -1);
        do_write(4'd7, 16'hA5A5);
        do_read(4'd7, 0);

        // Reset while beat 7 is pending, then a fresh dump
        do_dump(-1, 0, 7);
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        do_dump(-1, 0, -1);

        // Read held pending during a dump
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 4'd2;
        do_dump(-1, 0, -1);
        do_read(4'd2, 0);
        tick();
        chk("rd_once_vld",  32'(rsp_valid), 32'd0);
        chk("rd_once_busy", 32'(busy), 32'd0);

        // Random command mix against the reference register contents
        for (int i = 0; i < 60; i++) begin
            ra = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) do_write(ra, DW'($urandom));
            else                           do_read(ra, int'($urandom_range(0, 3)));
        end
        do_dump(int'($urandom_range(0, LAST)), int'($urandom_range(0, 4)), -1);
        do_dump(int'($urandom_range(0, LAST)), int'($urandom_range(1, 4)), -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
